// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - registered N:1 mux with loadable / round-robin scanning select
// Optional build macro MUX_SCAN_MASK_EN adds ch_mask to skip disabled channels while scanning.
module mux_scan_sequencer #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int DWELL = 4,
    localparam int SW   = $clog2(N),
    localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  din,
    input  logic [SW-1:0]   sel_in,
    input  logic            load,
    input  logic            scan_en,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N-1:0]    ch_mask,
`endif
    output logic [W-1:0]    d,
    output logic            d_valid,
    output logic [SW-1:0]   ch,
    output logic            wrap,
    output logic            sel_err
);

    typedef enum logic {HOLD = 1'b0, SCAN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    d_q;
    logic [SW-1:0]   ch_q;
    logic            d_valid_q, wrap_q, sel_err_q;

    logic            step_en, load_ok, load_bad;
    logic [SW-1:0]   nxt_sel;
    logic            nxt_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= HOLD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = scan_en ? SCAN : HOLD;
    end

    // Entering SCAN steps on the same edge, so the dwell count starts at once.
    always_comb begin
        load_ok  = load && (int'(sel_in) < N);
        load_bad = load && (int'(sel_in) >= N);
        case (state_q)
            SCAN:    step_en = !load && scan_en;
            default: step_en = !load && (state_d == SCAN);
        endcase
    end

    always_comb begin
        nxt_sel  = sel_q;
        nxt_wrap = 1'b0;
`ifdef MUX_SCAN_MASK_EN
        begin
            int  idx;
            logic found;
            idx   = 0;
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = int'(sel_q) + k;
                if (idx >= N) idx = idx - N;
                if (!found && ch_mask[idx[SW-1:0]]) begin
                    found    = 1'b1;
                    nxt_sel  = idx[SW-1:0];
                    nxt_wrap = (int'(sel_q) + k) >= N;
                end
            end
        end
`else
        if (sel_q == SW'(N - 1)) begin
            nxt_sel  = '0;
            nxt_wrap = 1'b1;
        end else begin
            nxt_sel  = sel_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= '0;
            cnt_q     <= '0;
            d_q       <= '0;
            ch_q      <= '0;
            d_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            d_q       <= din[int'(sel_q)*W +: W];
            ch_q      <= sel_q;
            d_valid_q <= 1'b1;
            wrap_q    <= 1'b0;
            sel_err_q <= 1'b0;
            if (load_ok) begin
                sel_q <= sel_in;
                cnt_q <= '0;
            end else if (load_bad) begin
                sel_err_q <= 1'b1;
            end else if (step_en) begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    cnt_q  <= '0;
                    sel_q  <= nxt_sel;
                    wrap_q <= nxt_wrap;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign d       = d_q;
    assign d_valid = d_valid_q;
    assign ch      = ch_q;
    assign wrap    = wrap_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - directed scoreboard bench for mux_scan_sequencer
module tb_mux_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] din_a;
    logic [1:0]  sel_in_a;
    logic        load_a, scan_en_a;
    logic [7:0]  d_a;
    logic        d_valid_a, wrap_a, sel_err_a;
    logic [1:0]  ch_a;

    logic [19:0] din_b;
    logic [2:0]  sel_in_b;
    logic        load_b, scan_en_b;
    logic [3:0]  d_b;
    logic        d_valid_b, wrap_b, sel_err_b;
    logic [2:0]  ch_b;

`ifdef MUX_SCAN_MASK_EN
    logic [15:0] din_c;
    logic [1:0]  sel_in_c;
    logic        load_c, scan_en_c;
    logic [3:0]  mask_c;
    logic [3:0]  d_c;
    logic        d_valid_c, wrap_c, sel_err_c;
    logic [1:0]  ch_c;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mux_scan_sequencer #(.N(4), .W(8), .DWELL(4)) u_a (
        .clk(clk), .rst(rst), .din(din_a), .sel_in(sel_in_a), .load(load_a),
        .scan_en(scan_en_a),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(4'hF),
`endif
        .d(d_a), .d_valid(d_valid_a), .ch(ch_a), .wrap(wrap_a), .sel_err(sel_err_a)
    );

    mux_scan_sequencer #(.N(5), .W(4), .DWELL(1)) u_b (
        .clk(clk), .rst(rst), .din(din_b), .sel_in(sel_in_b), .load(load_b),
        .scan_en(scan_en_b),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask(5'h1F),
`endif
        .d(d_b), .d_valid(d_valid_b), .ch(ch_b), .wrap(wrap_b), .sel_err(sel_err_b)
    );

`ifdef MUX_SCAN_MASK_EN
    mux_scan_sequencer #(.N(4), .W(4), .DWELL(1)) u_c (
        .clk(clk), .rst(rst), .din(din_c), .sel_in(sel_in_c), .load(load_c),
        .scan_en(scan_en_c), .ch_mask(mask_c),
        .d(d_c), .d_valid(d_valid_c), .ch(ch_c), .wrap(wrap_c), .sel_err(sel_err_c)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed %0h expected queued entry (queue empty)", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // Reset with scan_en low, then release with scan_en high so edge 1 is the first scan edge.
    task automatic restart_scan();
        rst       = 1'b1;
        scan_en_a = 1'b0;
        load_a    = 1'b0;
        tick();
        scan_en_a = 1'b1;
        rst       = 1'b0;
    endtask

    initial begin
        logic [1:0] ech;
        rst = 1'b1;
        din_a = '0; sel_in_a = '0; load_a = 1'b0; scan_en_a = 1'b0;
        din_b = '0; sel_in_b = '0; load_b = 1'b0; scan_en_b = 1'b0;
`ifdef MUX_SCAN_MASK_EN
        din_c = 16'h4321; sel_in_c = '0; load_c = 1'b0; scan_en_c = 1'b0; mask_c = 4'b1010;
`endif
        repeat (2) tick();

        check("rst_d",       32'(d_a),       32'h0);
        check("rst_d_valid", 32'(d_valid_a), 32'h0);
        check("rst_ch",      32'(ch_a),      32'h0);
        check("rst_wrap",    32'(wrap_a),    32'h0);
        check("rst_sel_err", 32'(sel_err_a), 32'h0);

        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            din_a    = 32'hA5 << (8 * s);
            sel_in_a = 2'(s);
            load_a   = 1'b1;
            tick();
            load_a   = 1'b0;
            exp_q.push_back({22'h0, 2'(s), 8'hA5});
            tick();
            pop_check("load_onehot_ch_d", {22'h0, ch_a, d_a});
        end
        check("load_d_valid", 32'(d_valid_a), 32'h1);
        din_a = '0;
        for (int s = 0; s < 4; s++) begin
            sel_in_a = 2'(s);
            load_a   = 1'b1;
            tick();
            load_a   = 1'b0;
            exp_q.push_back({22'h0, 2'(s), 8'h00});
            tick();
            pop_check("load_zero_ch_d", {22'h0, ch_a, d_a});
        end

        din_a = 32'h0804_0201;
        for (int j = 1; j <= 34; j++) begin
            ech = 2'(((j - 1) / 4) % 4);
            exp_q.push_back({21'h0, 1'((j % 16) == 0), ech, 8'(8'h01 << ech)});
        end
        restart_scan();
        for (int j = 1; j <= 34; j++) begin
            tick();
            pop_check("scan_wrap_ch_d", {21'h0, wrap_a, ch_a, d_a});
        end

        for (int e = 1; e <= 14; e++)
            exp_q.push_back((e <= 9) ? 32'h0 : (e <= 13) ? 32'h1 : 32'h2);
        restart_scan();
        for (int e = 1; e <= 14; e++) begin
            scan_en_a = !(e >= 3 && e <= 7);
            tick();
            pop_check("pause_ch", 32'(ch_a));
        end

        restart_scan();
        repeat (10) tick();
        check("midscan_ch", 32'(ch_a), 32'h2);
        rst = 1'b1;
        #1;
        check("async_rst_d",       32'(d_a),       32'h0);
        check("async_rst_d_valid", 32'(d_valid_a), 32'h0);
        check("async_rst_ch",      32'(ch_a),      32'h0);
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) exp_q.push_back((e <= 4) ? 32'h0 : 32'h1);
        for (int e = 1; e <= 5; e++) begin
            tick();
            pop_check("rst_resume_ch", 32'(ch_a));
            if (e == 1) check("rst_resume_d_valid", 32'(d_valid_a), 32'h1);
        end
        scan_en_a = 1'b0;

        din_b = 20'h54321;
        sel_in_b = 3'd2; load_b = 1'b1; tick();
        load_b = 1'b0; tick();
        check("n5_ch_after_load2", 32'(ch_b), 32'h2);
        sel_in_b = 3'd6; load_b = 1'b1; tick();
        check("n5_err_sel6",  32'(sel_err_b), 32'h1);
        check("n5_ch_keep",   32'(ch_b),      32'h2);
        load_b = 1'b0; tick();
        check("n5_err_pulse", 32'(sel_err_b), 32'h0);
        check("n5_ch_hold",   32'(ch_b),      32'h2);
        sel_in_b = 3'd5; load_b = 1'b1; tick();
        check("n5_err_sel5",  32'(sel_err_b), 32'h1);
        sel_in_b = 3'd4; tick();
        check("n5_err_sel4",  32'(sel_err_b), 32'h0);
        load_b = 1'b0; tick();
        check("n5_ch4_d",     {24'h0, 1'b0, ch_b, d_b}, {24'h0, 1'b0, 3'd4, 4'h5});
        check("n5_err_idle",  32'(sel_err_b), 32'h0);

`ifdef MUX_SCAN_MASK_EN
        scan_en_c = 1'b1;
        tick();
        check("mask_first_wrap", 32'(wrap_c), 32'h0);
        for (int e = 2; e <= 6; e++)
            exp_q.push_back({29'h0, 1'((e % 2) == 1), ((e % 2) == 0) ? 2'd1 : 2'd3});
        for (int e = 2; e <= 6; e++) begin
            tick();
            pop_check("mask_wrap_ch", {29'h0, wrap_c, ch_c});
        end
        mask_c = 4'b0000;
        for (int e = 7; e <= 9; e++) begin
            tick();
            check("mask_zero_wrap_ch", {29'h0, wrap_c, ch_c}, {29'h0, 1'b0, 2'd3});
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
